// File: rtl/piano_pkg.sv
// Shared constants and FSM state type for the 12-key polyphony controller.
package piano_pkg;

  localparam int NUM_KEYS    = 12;
  localparam int KEY_IDX_W   = 4;
  localparam int KEY_COUNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/voice_allocator_if.sv
// Key-scan request and voice-allocation result bundle between the keyboard front end and the allocator.
interface voice_allocator_if #(
  parameter int NUM_VOICES = 4
);
  import piano_pkg::*;

  logic [NUM_KEYS-1:0]     keys;
  logic                    start;
  logic                    busy;
  logic                    scan_done;
  logic [NUM_VOICES-1:0]   voice_active;
  logic [4*NUM_VOICES-1:0] voice_note;
  logic [KEY_COUNT_W-1:0]  key_count;
  logic                    drop_flag;

  modport master (
    output keys, start,
    input  busy, scan_done, voice_active, voice_note, key_count, drop_flag
  );

  modport slave (
    input  keys, start,
    output busy, scan_done, voice_active, voice_note, key_count, drop_flag
  );
endinterface

// File: rtl/voice_allocator_key_popcount.sv
// Combinational count of pressed keys in a 12-bit key snapshot.
module key_popcount
  import piano_pkg::*;
(
  input  logic [NUM_KEYS-1:0]    bits_in,
  output logic [KEY_COUNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      count = count + KEY_COUNT_W'(bits_in[i]);
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Maps pressed keys onto NUM_VOICES voices, one key per SCAN cycle.
// Define VOICE_STEAL_EN to steal the oldest voice instead of dropping a key when the pool is full.
module voice_allocator
  import piano_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 4
) (
  input  logic            clk,
  input  logic            reset,
  voice_allocator_if.slave bus
);

  localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [KEY_IDX_W-1:0] LAST_IDX = KEY_IDX_W'(NUM_KEYS - 1);

  state_e                                 state_q, state_d;
  logic [NUM_KEYS-1:0]                    snap_q, snap_d;
  logic [KEY_IDX_W-1:0]                   idx_q, idx_d;
  logic                                   drop_acc_q, drop_acc_d;
  logic [NUM_VOICES-1:0]                  active_q, active_d;
  logic [NUM_VOICES-1:0][KEY_IDX_W-1:0]   note_q, note_d;
  logic [NUM_VOICES-1:0][AGE_W-1:0]       age_q, age_d;
  logic [KEY_COUNT_W-1:0]                 key_count_q, key_count_d;
  logic                                   drop_flag_q, drop_flag_d;
  logic                                   scan_done_q, scan_done_d;

  logic [KEY_COUNT_W-1:0] snap_count;
  logic                   held;
  logic [VIDX_W-1:0]      held_v;
  logic                   free_found;
  logic [VIDX_W-1:0]      free_v;
`ifdef VOICE_STEAL_EN
  logic [VIDX_W-1:0]      old_v;
  logic [AGE_W-1:0]       old_age;
`endif

  key_popcount u_popcount (
    .bits_in (snap_q),
    .count   (snap_count)
  );

  // Priority searches over the voice pool for the key currently being scanned.
  always_comb begin
    held       = 1'b0;
    held_v     = '0;
    free_found = 1'b0;
    free_v     = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!held && active_q[v] && note_q[v] == idx_q) begin
        held   = 1'b1;
        held_v = VIDX_W'(v);
      end
    end
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!active_q[v]) begin
        free_found = 1'b1;
        free_v     = VIDX_W'(v);
      end
    end
  end

`ifdef VOICE_STEAL_EN
  // Strict greater-than keeps the lowest index on equal ages.
  always_comb begin
    old_v   = '0;
    old_age = age_q[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age_q[v] > old_age) begin
        old_v   = VIDX_W'(v);
        old_age = age_q[v];
      end
    end
  end
`endif

  // NOTE: every *_d gets its hold value first, so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    idx_d       = idx_q;
    drop_acc_d  = drop_acc_q;
    active_d    = active_q;
    note_d      = note_q;
    age_d       = age_q;
    key_count_d = key_count_q;
    drop_flag_d = drop_flag_q;
    scan_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          snap_d     = bus.keys;
          drop_acc_d = 1'b0;
          idx_d      = '0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (snap_q[idx_q] && !held) begin
          if (free_found) begin
            active_d[free_v] = 1'b1;
            note_d[free_v]   = idx_q;
            age_d[free_v]    = '0;
          end else begin
`ifdef VOICE_STEAL_EN
            note_d[old_v] = idx_q;
            age_d[old_v]  = '0;
`else
            drop_acc_d = 1'b1;
`endif
          end
        end else if (!snap_q[idx_q] && held) begin
          active_d[held_v] = 1'b0;
          age_d[held_v]    = '0;
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        key_count_d = snap_count;
        drop_flag_d = drop_acc_q;
        scan_done_d = 1'b1;
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (active_q[v] && age_q[v] != '1) begin
            age_d[v] = age_q[v] + 1'b1;
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values; the voice table is reset too because its contents are visible on outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      snap_q      <= '0;
      idx_q       <= '0;
      drop_acc_q  <= 1'b0;
      active_q    <= '0;
      note_q      <= '0;
      age_q       <= '0;
      key_count_q <= '0;
      drop_flag_q <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      idx_q       <= idx_d;
      drop_acc_q  <= drop_acc_d;
      active_q    <= active_d;
      note_q      <= note_d;
      age_q       <= age_d;
      key_count_q <= key_count_d;
      drop_flag_q <= drop_flag_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.scan_done    = scan_done_q;
  assign bus.voice_active = active_q;
  assign bus.voice_note   = note_q;
  assign bus.key_count    = key_count_q;
  assign bus.drop_flag    = drop_flag_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator (4 voices); steal scenarios run when VOICE_STEAL_EN is defined.
module tb_voice_allocator;
  import piano_pkg::*;

  typedef struct {
    int          exp_cycle;
    logic [3:0]  active;
    logic [15:0] note;
    logic [5:0]  count;
    logic        drop;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t sb[$];

  voice_allocator_if #(.NUM_VOICES(4)) bus ();

  voice_allocator #(.NUM_VOICES(4), .AGE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every published scan against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && bus.scan_done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_scan_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("scan_latency", cyc, e.exp_cycle);
        check("voice_active", {28'd0, bus.voice_active}, {28'd0, e.active});
        check("voice_note", {16'd0, bus.voice_note}, {16'd0, e.note});
        check("key_count", {26'd0, bus.key_count}, {26'd0, e.count});
        check("drop_flag", {31'd0, bus.drop_flag}, {31'd0, e.drop});
      end
    end
  end

  task automatic run_scan(input logic [11:0] k, input logic [3:0] act,
                          input logic [15:0] note, input logic [5:0] cnt, input logic drop);
    exp_t e;
    bit   done;
    @(negedge clk);
    bus.keys  = k;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    e.exp_cycle = cyc + 13;
    e.active    = act;
    e.note      = note;
    e.count     = cnt;
    e.drop      = drop;
    sb.push_back(e);
    // Scan inputs change mid-scan to confirm only the snapshot is used.
    bus.keys = ~k;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) done = 1'b1;
    end
    if (!done) begin
      check("scan_timeout", 32'd1, 32'd0);
      sb.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_scan_done"}, {31'd0, bus.scan_done}, 32'd0);
    check({tag, "_active"}, {28'd0, bus.voice_active}, 32'd0);
    check({tag, "_note"}, {16'd0, bus.voice_note}, 32'd0);
    check({tag, "_count"}, {26'd0, bus.key_count}, 32'd0);
    check({tag, "_drop"}, {31'd0, bus.drop_flag}, 32'd0);
  endtask

  initial begin
    bit         saw_done;
    int         dups;
    logic [3:0] n_i, n_j;

    bus.keys  = 12'hFFF;
    bus.start = 1'b1;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_busy", {31'd0, bus.busy}, 32'd0);

    run_scan(12'h001, 4'h1, 16'h0000, 6'd1, 1'b0);
    run_scan(12'h000, 4'h0, 16'h0000, 6'd0, 1'b0);

`ifdef VOICE_STEAL_EN
    run_scan(12'h00F, 4'hF, 16'h3210, 6'd4, 1'b0);
    run_scan(12'h00F, 4'hF, 16'h3210, 6'd4, 1'b0);
    run_scan(12'h00F, 4'hF, 16'h3210, 6'd4, 1'b0);
    run_scan(12'h10F, 4'hF, 16'h3218, 6'd5, 1'b0);
    run_scan(12'h10F, 4'hF, 16'h2108, 6'd5, 1'b0);
`else
    run_scan(12'h01F, 4'hF, 16'h3210, 6'd5, 1'b1);
    run_scan(12'h010, 4'h1, 16'h3214, 6'd1, 1'b0);
    run_scan(12'h800, 4'h1, 16'h321B, 6'd1, 1'b0);
    run_scan(12'hFFF, 4'hF, 16'h210B, 6'd12, 1'b1);
    run_scan(12'hE00, 4'h7, 16'h2A9B, 6'd3, 1'b0);
`endif

    dups = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        n_i = bus.voice_note[4*i +: 4];
        n_j = bus.voice_note[4*j +: 4];
        if (bus.voice_active[i] && bus.voice_active[j] && n_i == n_j) dups++;
      end
    end
    check("no_duplicate_notes", dups, 32'd0);

    // Reset during the sixth SCAN cycle discards the scan.
    @(negedge clk);
    bus.keys  = 12'h0F0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_scan_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("mid_reset");
    reset    = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.scan_done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
    end
    check("no_scan_after_reset", {31'd0, saw_done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
